dom_indep_pipe: RTL and testbench

DOM_INDEP_PIPE -- requirements
Module: dom_indep_pipe

---
 rtl/dom_indep_pipe.sv | 106 ++++++++++
 tb/tb_dom_indep_pipe.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dom_indep_pipe.sv
// First-order-and-up domain-oriented masked AND over WIDTH independent bit-lanes, valid/ready pipelined.
// Optional macro DOM_OUTPUT_REG_EN adds a registered output stage holding the compressed shares.
module dom_indep_pipe #(
   parameter int unsigned ORDER = 1,
   parameter int unsigned WIDTH = 1
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic [(ORDER+1)*WIDTH-1:0]            port_a,
   input  logic [(ORDER+1)*WIDTH-1:0]            port_b,
   input  logic [(ORDER*(ORDER+1)/2)*WIDTH-1:0]  port_r,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   output logic [(ORDER+1)*WIDTH-1:0]            port_c,
   output logic                                  out_valid,
   input  logic                                  out_ready
);

   localparam int unsigned SHARES = ORDER + 1;
   localparam int unsigned SW     = SHARES * WIDTH;
   localparam int unsigned TW     = SHARES * SHARES * WIDTH;

   // term slot (i,j): i==j holds the inner product, i!=j the refreshed cross term owned by domain i
   logic [TW-1:0] term_d;
   logic [TW-1:0] term_q;
   logic [SW-1:0] c_comb;
   logic          s1_full;
   logic          s1_drain;
   logic          ld1;

   for (genvar gi = 0; gi < SHARES; gi++) begin : g_dom
      for (genvar gj = 0; gj < SHARES; gj++) begin : g_term
         if (gi == gj) begin : g_inner
            assign term_d[(gi*SHARES+gj)*WIDTH +: WIDTH] =
               port_a[gi*WIDTH +: WIDTH] & port_b[gi*WIDTH +: WIDTH];
         end else begin : g_cross
            // (i,j) and (j,i) share the same lexicographic randomness pair
            localparam int unsigned LO = (gi < gj) ? 32'(gi) : 32'(gj);
            localparam int unsigned HI = (gi < gj) ? 32'(gj) : 32'(gi);
            localparam int unsigned P  = LO * (2 * ORDER - LO + 1) / 2 + (HI - LO - 1);
            assign term_d[(gi*SHARES+gj)*WIDTH +: WIDTH] =
               (port_a[gi*WIDTH +: WIDTH] & port_b[gj*WIDTH +: WIDTH]) ^ port_r[P*WIDTH +: WIDTH];
         end
      end
   end

   // per-domain compression strictly after the stage-1 registers
   always_comb begin
      c_comb = '0;
      for (int unsigned i = 0; i < SHARES; i++) begin
         for (int unsigned j = 0; j < SHARES; j++) begin
            c_comb[i*WIDTH +: WIDTH] = c_comb[i*WIDTH +: WIDTH] ^ term_q[(i*SHARES+j)*WIDTH +: WIDTH];
         end
      end
   end

   assign ld1 = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         term_q  <= '0;
         s1_full <= 1'b0;
      end else begin
         if (ld1) begin
            term_q <= term_d;
         end
         if (ld1) begin
            s1_full <= 1'b1;
         end else if (s1_drain) begin
            s1_full <= 1'b0;
         end
      end
   end

`ifdef DOM_OUTPUT_REG_EN
   logic          s2_full;
   logic          ready2;
   logic [SW-1:0] c_q;

   assign ready2    = !s2_full || out_ready;
   assign s1_drain  = s1_full && ready2;
   assign in_ready  = !s1_full || ready2;
   assign out_valid = s2_full;
   assign port_c    = c_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_q     <= '0;
         s2_full <= 1'b0;
      end else begin
         if (s1_drain) begin
            c_q     <= c_comb;
            s2_full <= 1'b1;
         end else if (out_ready) begin
            s2_full <= 1'b0;
         end
      end
   end
`else
   assign s1_drain  = out_ready;
   assign in_ready  = !s1_full || out_ready;
   assign out_valid = s1_full;
   assign port_c    = c_comb;
`endif

endmodule

// File: tb/tb_dom_indep_pipe.sv
// Scoreboard bench: ORDER=1/WIDTH=1 instance with hand-computed share vectors, ORDER=2/WIDTH=4 instance for unmasked AND.
module tb_dom_indep_pipe;

`ifdef DOM_OUTPUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [1:0]  a1, b1, c1;
   logic [0:0]  r1;
   logic        iv1, ir1, ov1, or1;
   logic [11:0] a2, b2, r2, c2;
   logic        iv2, ir2, ov2, or2;

   int vectors = 0;
   int miscompares = 0;
   logic [1:0] q1[$];
   logic [3:0] q2[$];
   logic [6:0] vec [8];

   dom_indep_pipe #(.ORDER(1), .WIDTH(1)) u_o1 (
      .clk(clk), .rst_n(rst_n), .port_a(a1), .port_b(b1), .port_r(r1),
      .in_valid(iv1), .in_ready(ir1), .port_c(c1), .out_valid(ov1), .out_ready(or1));

   dom_indep_pipe #(.ORDER(2), .WIDTH(4)) u_o2 (
      .clk(clk), .rst_n(rst_n), .port_a(a2), .port_b(b2), .port_r(r2),
      .in_valid(iv2), .in_ready(ir2), .port_c(c2), .out_valid(ov2), .out_ready(or2));

   function automatic logic [3:0] unmask(input logic [11:0] s);
      return s[3:0] ^ s[7:4] ^ s[11:8];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // output monitors: pop and compare on every delivery
   always @(negedge clk) begin
      if (rst_n && ov1 && or1) begin
         if (q1.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL c1_unexpected: got %0h expected no output", c1);
         end else begin
            check("c1_shares", 32'(c1), 32'(q1.pop_front()));
         end
      end
      if (rst_n && ov2 && or2) begin
         if (q2.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL c2_unexpected: got %0h expected no output", c2);
         end else begin
            check("c2_and", 32'(unmask(c2)), 32'(q2.pop_front()));
         end
      end
   end

   // called at posedge+1; returns at posedge+1 after the transfer edge
   task automatic send1(input logic [6:0] v, output int waited);
      bit ok = 0;
      a1 = v[6:5]; b1 = v[4:3]; r1 = v[2]; iv1 = 1'b1;
      waited = 0;
      while (!ok) begin
         @(negedge clk);
         if (ir1) ok = 1;
         else begin
            waited++;
            if (waited > 50) begin
               vectors++; miscompares++;
               $display("FAIL send1_timeout: got in_ready 0 expected 1");
               break;
            end
         end
      end
      if (ok) q1.push_back(v[1:0]);
      @(posedge clk); #1;
      iv1 = 1'b0;
   endtask

   task automatic send2(input logic [11:0] a, input logic [11:0] b, input logic [11:0] r);
      bit ok = 0;
      int waited = 0;
      a2 = a; b2 = b; r2 = r; iv2 = 1'b1;
      while (!ok) begin
         @(negedge clk);
         if (ir2) ok = 1;
         else begin
            waited++;
            if (waited > 50) begin
               vectors++; miscompares++;
               $display("FAIL send2_timeout: got in_ready 0 expected 1");
               break;
            end
            @(posedge clk); #1;
            or2 = 1'b1;
         end
      end
      if (ok) q2.push_back(unmask(a) & unmask(b));
      @(posedge clk); #1;
      iv2 = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int w;
      // {a[1:0], b[1:0], r, c[1:0]}
      vec = '{7'b01_10_1_10, 7'b01_10_0_01, 7'b01_00_1_11, 7'b11_01_0_11,
              7'b10_01_1_01, 7'b11_11_0_00, 7'b10_10_0_10, 7'b00_11_1_11};
      rst_n = 1'b0;
      a1 = '0; b1 = '0; r1 = '0; iv1 = 1'b0; or1 = 1'b1;
      a2 = '0; b2 = '0; r2 = '0; iv2 = 1'b0; or2 = 1'b1;
      #2;
      check("rst_ready1", 32'(ir1), 1);
      check("rst_valid1", 32'(ov1), 0);
      check("rst_c1", 32'(c1), 0);
      check("rst_ready2", 32'(ir2), 1);
      check("rst_valid2", 32'(ov2), 0);
      check("rst_c2", 32'(c2), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      check("post_rst_ready", 32'(ir1), 1);
      @(posedge clk); #1;

      // first-result latency and basic sharing cases
      send1(vec[0], w);
      for (int k = 1; k <= LAT; k++) begin
         @(negedge clk);
         check("lat_valid", 32'(ov1), 32'(k == LAT));
      end
      @(posedge clk); #1;
      send1(vec[1], w);
      send1(vec[2], w);
      repeat (LAT + 1) @(posedge clk);
      #1;

      // stall: result must hold while inputs wander
      or1 = 1'b0;
      send1(vec[0], w);
      repeat (LAT - 1) begin @(posedge clk); #1; end
      if (LAT == 1) begin
         a1 = 2'b11; b1 = 2'b11; r1 = 1'b0; iv1 = 1'b1;
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("stall_valid", 32'(ov1), 1);
         check("stall_c", 32'(c1), 32'(2'b10));
         check("stall_ready", 32'(ir1), (LAT == 1) ? 0 : 1);
         @(posedge clk); #1;
         a1 = 2'($urandom); b1 = 2'($urandom); r1 = 1'($urandom);
      end
      or1 = 1'b1;
      send1(vec[6], w);
      check("release_accept", 32'(w), 0);
      repeat (LAT + 1) @(posedge clk);
      #1;

      // back-to-back
      for (int i = 0; i < 8; i++) begin
         send1(vec[i], w);
         check("b2b_ready", 32'(w), 0);
      end
      repeat (LAT + 1) @(posedge clk);
      #1;
      check("b2b_drained", 32'(q1.size()), 0);

      // reset while a result is in flight
      or1 = 1'b0;
      send1(vec[4], w);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_valid", 32'(ov1), 0);
      check("midrst_c", 32'(c1), 0);
      check("midrst_ready", 32'(ir1), 1);
      q1.delete();
      q2.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      or1 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("post_midrst_valid", 32'(ov1), 0);
      end
      @(posedge clk); #1;

      // ORDER=2, WIDTH=4 with random shares and backpressure
      for (int n = 0; n < 1000; n++) begin
         or2 = ($urandom_range(0, 3) != 0);
         send2(12'($urandom), 12'($urandom), 12'($urandom));
      end
      or1 = 1'b1;
      or2 = 1'b1;
      for (int k = 0; k < 20 && (q1.size() != 0 || q2.size() != 0); k++) begin
         @(posedge clk); #1;
      end
      check("final_q1_empty", 32'(q1.size()), 0);
      check("final_q2_empty", 32'(q2.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
